// File: rtl/msp430_mem_pkg.sv
// Shared definitions for the MSP430 memory-side bus responders and memory-map decoders.
// Holds the responder state encoding, the vacant-memory read pattern and the default RAM window.
package msp430_mem_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } mem_state_e;

  localparam logic [15:0] VACANT_DATA    = 16'h3FFF;
  localparam logic [15:0] RAM_BASE_DFLT  = 16'h0200;
  localparam int          RAM_DEPTH_DFLT = 512;

  // Word accesses drive both lanes; byte accesses select the lane from address bit 0.
  function automatic logic [1:0] lane_en(input logic bw, input logic a0);
    if (!bw) return 2'b11;
    return a0 ? 2'b10 : 2'b01;
  endfunction

endpackage

// File: rtl/mem_ram_array.sv
// Single-port DEPTH_WORDS x 16 RAM: combinational read, synchronous write with per-byte lane enables.
// Contents are never reset.
module mem_ram_array #(
  parameter int DEPTH_WORDS = 512,
  parameter int AW          = 9
) (
  input  logic          clk,
  input  logic [AW-1:0] addr,
  input  logic          wr_en,
  input  logic [1:0]    byte_en,
  input  logic [15:0]   wdata,
  output logic [15:0]   rdata
);

  logic [15:0] mem [DEPTH_WORDS];

  always_ff @(posedge clk) begin
    if (wr_en) begin
      if (byte_en[0]) mem[addr][7:0]  <= wdata[7:0];
      if (byte_en[1]) mem[addr][15:8] <= wdata[15:8];
    end
  end

  assign rdata = mem[addr];

endmodule

// File: rtl/mem_bus_responder.sv
// MAB/MDB memory responder: latches one CPU access, decodes it against the RAM window,
// waits WAIT_STATES cycles and acknowledges for one cycle with read data or an error flag.
module mem_bus_responder
  import msp430_mem_pkg::*;
#(
  parameter logic [15:0] BASE_ADDR   = RAM_BASE_DFLT,
  parameter int          DEPTH_WORDS = RAM_DEPTH_DFLT,
  parameter int          WAIT_STATES = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] MAB_in,
  input  logic [15:0] MDB_out,
  input  logic        MEM_REQ,
  input  logic        MEM_WE,
  input  logic        MEM_BW,
  output logic [15:0] MDB_in,
  output logic        MEM_ACK,
  output logic        MEM_ERR
);

  localparam int          AW     = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam logic [16:0] WIN_LO = {1'b0, BASE_ADDR};
  localparam logic [16:0] WIN_HI = WIN_LO + 17'(2 * DEPTH_WORDS);
  localparam logic [2:0]  WS     = 3'(WAIT_STATES);

  mem_state_e    state_q, state_d;
  logic [2:0]    cnt_q, cnt_d;
  logic          accept;

  logic [15:0]   addr_q;
  logic [15:0]   wdata_q;
  logic          we_q;
  logic          bw_q;
  logic          hit_q;
  logic [15:0]   rd_hold_q;

  logic [16:0]   req_addr17;
  logic          req_hit;
  logic [15:0]   off;
  logic [15:0]   off_sh;
  logic [AW-1:0] idx;
  logic          unused_off;

  logic          ram_we;
  logic [1:0]    ram_be;
  logic [15:0]   ram_wdata;
  logic [15:0]   ram_rdata;
  logic [15:0]   rd_val;
  logic          rd_resp;

  // 17-bit compare so a window ending at the top of the 64K space cannot wrap.
  assign req_addr17 = {1'b0, MAB_in};
  assign req_hit    = (req_addr17 >= WIN_LO) && (req_addr17 < WIN_HI);

  // Word index drops bit 0, so word accesses to odd addresses land on the even word.
  assign off        = addr_q - BASE_ADDR;
  assign off_sh     = off >> 1;
  assign idx        = off_sh[AW-1:0];
  assign unused_off = ^{off[0], off_sh};

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    accept  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (MEM_REQ) begin
          accept = 1'b1;
          if (WS == 3'd0) begin
            state_d = RESP;
          end else begin
            cnt_d   = WS;
            state_d = WAIT;
          end
        end
      end
      WAIT: begin
        if (cnt_q <= 3'd1) begin
          cnt_d   = 3'd0;
          state_d = RESP;
        end else begin
          cnt_d = cnt_q - 3'd1;
        end
      end
      RESP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
        cnt_d   = 3'd0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      cnt_q     <= 3'd0;
      rd_hold_q <= 16'h0000;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (rd_resp) rd_hold_q <= rd_val;
    end
  end

  // Access attributes are captured once at acceptance and held until the acknowledge.
  always_ff @(posedge clk) begin
    if (accept) begin
      addr_q  <= MAB_in;
      wdata_q <= MDB_out;
      we_q    <= MEM_WE;
      bw_q    <= MEM_BW;
      hit_q   <= req_hit;
    end
  end

  // A reset arriving on the acknowledge edge must still cancel the write.
  assign ram_we    = rst_n && (state_q == RESP) && we_q && hit_q;
  assign ram_be    = lane_en(bw_q, addr_q[0]);
  assign ram_wdata = bw_q ? {wdata_q[7:0], wdata_q[7:0]} : wdata_q;

  mem_ram_array #(
    .DEPTH_WORDS (DEPTH_WORDS),
    .AW          (AW)
  ) u_ram (
    .clk     (clk),
    .addr    (idx),
    .wr_en   (ram_we),
    .byte_en (ram_be),
    .wdata   (ram_wdata),
    .rdata   (ram_rdata)
  );

  always_comb begin
    rd_val = VACANT_DATA;
    if (hit_q) begin
      if (bw_q) rd_val = {8'h00, addr_q[0] ? ram_rdata[15:8] : ram_rdata[7:0]};
      else      rd_val = ram_rdata;
    end
  end

  // Read data is driven live during the acknowledge cycle and held afterwards.
  assign rd_resp = (state_q == RESP) && !we_q;
  assign MDB_in  = rd_resp ? rd_val : rd_hold_q;
  assign MEM_ACK = (state_q == RESP);
  assign MEM_ERR = (state_q == RESP) && !hit_q;

endmodule

// File: tb/tb_mem_bus_responder.sv
// Bench for mem_bus_responder: directed vector table, reset-abort sequences,
// randomized accesses against a behavioural RAM model, and wait-state timing on extra instances.
module tb_mem_bus_responder;

  localparam int MBASE = 32'h0200;
  localparam int MDEP  = 512;

  logic        clk;
  logic        rst_n;
  logic [15:0] MAB_in;
  logic [15:0] MDB_out;
  logic        MEM_REQ;
  logic        MEM_WE;
  logic        MEM_BW;
  logic [15:0] MDB_in;
  logic        MEM_ACK;
  logic        MEM_ERR;

  logic [2:0]  req_w;
  logic [2:0]  ack_w;
  logic [2:0]  err_w;
  logic [15:0] mdb_w [3];

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  logic [15:0] mdl [MDEP];
  logic [15:0] mdl_hold;

  typedef struct {
    logic        we;
    logic        bw;
    logic [15:0] addr;
    logic [15:0] wdata;
    logic [15:0] exp_rd;
    logic        exp_err;
  } vec_t;

  vec_t tbl [20];

  mem_bus_responder #(.WAIT_STATES(1)) dut (
    .clk(clk), .rst_n(rst_n), .MAB_in(MAB_in), .MDB_out(MDB_out), .MEM_REQ(MEM_REQ),
    .MEM_WE(MEM_WE), .MEM_BW(MEM_BW), .MDB_in(MDB_in), .MEM_ACK(MEM_ACK), .MEM_ERR(MEM_ERR)
  );

  mem_bus_responder #(.WAIT_STATES(0)) dut_ws0 (
    .clk(clk), .rst_n(rst_n), .MAB_in(MAB_in), .MDB_out(MDB_out), .MEM_REQ(req_w[0]),
    .MEM_WE(MEM_WE), .MEM_BW(MEM_BW), .MDB_in(mdb_w[0]), .MEM_ACK(ack_w[0]), .MEM_ERR(err_w[0])
  );

  mem_bus_responder #(.WAIT_STATES(3)) dut_ws3 (
    .clk(clk), .rst_n(rst_n), .MAB_in(MAB_in), .MDB_out(MDB_out), .MEM_REQ(req_w[1]),
    .MEM_WE(MEM_WE), .MEM_BW(MEM_BW), .MDB_in(mdb_w[1]), .MEM_ACK(ack_w[1]), .MEM_ERR(err_w[1])
  );

  mem_bus_responder #(.WAIT_STATES(7)) dut_ws7 (
    .clk(clk), .rst_n(rst_n), .MAB_in(MAB_in), .MDB_out(MDB_out), .MEM_REQ(req_w[2]),
    .MEM_WE(MEM_WE), .MEM_BW(MEM_BW), .MDB_in(mdb_w[2]), .MEM_ACK(ack_w[2]), .MEM_ERR(err_w[2])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation time limit reached, got no end, required end of test");
    $fatal(1, "watchdog");
  end

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h required %h", nm, act, exp);
    end
  endtask

  task automatic access(input logic we, input logic bw, input logic [15:0] a, input logic [15:0] d,
                        output int lat, output logic [15:0] rd, output logic er);
    @(negedge clk);
    MAB_in = a; MDB_out = d; MEM_WE = we; MEM_BW = bw; MEM_REQ = 1'b1;
    @(posedge clk);
    #1 MEM_REQ = 1'b0;
    lat = 0; rd = 16'h0000; er = 1'b0;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      if (MEM_ACK) begin
        lat = i; rd = MDB_in; er = MEM_ERR;
        break;
      end
    end
  endtask

  task automatic run_vec(input string nm, input logic we, input logic bw, input logic [15:0] a,
                         input logic [15:0] d, input logic [15:0] exp_rd, input logic exp_err);
    int          lat;
    logic [15:0] rd;
    logic        er;
    access(we, bw, a, d, lat, rd, er);
    check({nm, "_lat"}, lat, 2);
    check({nm, "_rd"}, rd, exp_rd);
    check({nm, "_err"}, er, exp_err);
    @(negedge clk);
    check({nm, "_pulse"}, {MEM_ACK, MEM_ERR}, 0);
  endtask

  // Behavioural RAM: the window is [MBASE, MBASE+2*MDEP), odd word addresses read the even word.
  task automatic model_access(input logic we, input logic bw, input logic [15:0] a, input logic [15:0] d);
    int          ai;
    int          idx;
    logic        hit;
    logic [15:0] exp_rd;
    logic [15:0] w;
    ai  = int'(a);
    hit = (ai >= MBASE) && (ai < MBASE + 2 * MDEP);
    idx = hit ? (ai - MBASE) / 2 : 0;
    w   = mdl[idx];
    if (!we) begin
      if (!hit)    exp_rd = 16'h3FFF;
      else if (bw) exp_rd = a[0] ? {8'h00, w[15:8]} : {8'h00, w[7:0]};
      else         exp_rd = w;
      mdl_hold = exp_rd;
    end else begin
      exp_rd = mdl_hold;
      if (hit) begin
        if (!bw)      mdl[idx] = d;
        else if (a[0]) mdl[idx] = {d[7:0], w[7:0]};
        else          mdl[idx] = {w[15:8], d[7:0]};
      end
    end
    run_vec("rand", we, bw, a, d, exp_rd, !hit);
  endtask

  task automatic ws_access(input int k, input logic we, input logic [15:0] a, input logic [15:0] d,
                           output int lat, output logic [15:0] rd, output logic er);
    @(negedge clk);
    MAB_in = a; MDB_out = d; MEM_WE = we; MEM_BW = 1'b0; req_w[k] = 1'b1;
    @(posedge clk);
    #1 req_w[k] = 1'b0;
    lat = 0; rd = 16'h0000; er = 1'b0;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      if (ack_w[k]) begin
        lat = i; rd = mdb_w[k]; er = err_w[k];
        break;
      end
    end
  endtask

  task automatic ws_stream(input int k, input int ws);
    int t[$];
    @(negedge clk);
    MAB_in = 16'h0204; MEM_WE = 1'b0; MEM_BW = 1'b0; req_w[k] = 1'b1;
    for (int i = 0; i < 40 && t.size() < 3; i++) begin
      @(negedge clk);
      if (ack_w[k]) t.push_back(cyc);
    end
    req_w[k] = 1'b0;
    check($sformatf("ws%0d_stream_acks", ws), t.size(), 3);
    if (t.size() == 3) begin
      check($sformatf("ws%0d_spacing1", ws), t[1] - t[0], ws + 2);
      check($sformatf("ws%0d_spacing2", ws), t[2] - t[1], ws + 2);
    end
    repeat (ws + 4) @(negedge clk);
  endtask

  initial begin
    int          lat;
    logic [15:0] rd;
    logic        er;
    int          wsv [3];
    logic [15:0] pat;
    logic [15:0] ra;
    int          sel;

    wsv[0] = 0; wsv[1] = 3; wsv[2] = 7;
    rst_n = 1'b0; MAB_in = 16'h0000; MDB_out = 16'h0000;
    MEM_REQ = 1'b0; MEM_WE = 1'b0; MEM_BW = 1'b0; req_w = 3'b000;

    tbl[0]  = '{1'b1, 1'b0, 16'h0200, 16'hBEEF, 16'h0000, 1'b0};
    tbl[1]  = '{1'b0, 1'b0, 16'h0200, 16'h0000, 16'hBEEF, 1'b0};
    tbl[2]  = '{1'b1, 1'b0, 16'h0210, 16'h1234, 16'hBEEF, 1'b0};
    tbl[3]  = '{1'b1, 1'b1, 16'h0211, 16'hFFAB, 16'hBEEF, 1'b0};
    tbl[4]  = '{1'b0, 1'b0, 16'h0210, 16'h0000, 16'hAB34, 1'b0};
    tbl[5]  = '{1'b0, 1'b1, 16'h0210, 16'h0000, 16'h0034, 1'b0};
    tbl[6]  = '{1'b0, 1'b1, 16'h0211, 16'h0000, 16'h00AB, 1'b0};
    tbl[7]  = '{1'b0, 1'b0, 16'h0201, 16'h0000, 16'hBEEF, 1'b0};
    tbl[8]  = '{1'b0, 1'b0, 16'h01FF, 16'h0000, 16'h3FFF, 1'b1};
    tbl[9]  = '{1'b1, 1'b0, 16'h05FE, 16'h7777, 16'h3FFF, 1'b0};
    tbl[10] = '{1'b1, 1'b0, 16'h0600, 16'h1111, 16'h3FFF, 1'b1};
    tbl[11] = '{1'b0, 1'b0, 16'h05FE, 16'h0000, 16'h7777, 1'b0};
    tbl[12] = '{1'b0, 1'b0, 16'h0600, 16'h0000, 16'h3FFF, 1'b1};
    tbl[13] = '{1'b0, 1'b1, 16'hFFFF, 16'h0000, 16'h3FFF, 1'b1};
    tbl[14] = '{1'b1, 1'b0, 16'h0220, 16'h0000, 16'h3FFF, 1'b0};
    tbl[15] = '{1'b1, 1'b0, 16'h0222, 16'h0000, 16'h3FFF, 1'b0};
    tbl[16] = '{1'b0, 1'b0, 16'h0210, 16'h0000, 16'hAB34, 1'b0};
    tbl[17] = '{1'b1, 1'b0, 16'h0212, 16'h5678, 16'hAB34, 1'b0};
    tbl[18] = '{1'b1, 1'b1, 16'h0212, 16'h99EF, 16'hAB34, 1'b0};
    tbl[19] = '{1'b0, 1'b0, 16'h0212, 16'h0000, 16'h56EF, 1'b0};

    repeat (3) @(negedge clk);
    check("reset_ack", MEM_ACK, 0);
    check("reset_err", MEM_ERR, 0);
    check("reset_mdb", MDB_in, 16'h0000);
    rst_n = 1'b1;
    @(negedge clk);
    check("post_reset_outs", {MEM_ACK, MEM_ERR, MDB_in}, 0);

    foreach (tbl[i])
      run_vec($sformatf("vec%0d", i), tbl[i].we, tbl[i].bw, tbl[i].addr, tbl[i].wdata,
              tbl[i].exp_rd, tbl[i].exp_err);

    // Reset during WAIT: no acknowledge, outputs cleared, write dropped.
    @(negedge clk);
    MAB_in = 16'h0220; MDB_out = 16'h5555; MEM_WE = 1'b1; MEM_BW = 1'b0; MEM_REQ = 1'b1;
    @(posedge clk);
    #1 MEM_REQ = 1'b0;
    @(negedge clk);
    check("rstwait_pre_ack", MEM_ACK, 0);
    rst_n = 1'b0;
    @(negedge clk);
    check("rstwait_outs", {MEM_ACK, MEM_ERR, MDB_in}, 0);
    @(negedge clk);
    check("rstwait_outs2", {MEM_ACK, MEM_ERR, MDB_in}, 0);
    rst_n = 1'b1;
    run_vec("rstwait_read", 1'b0, 1'b0, 16'h0220, 16'h0000, 16'h0000, 1'b0);

    // Reset on the acknowledge edge must still suppress the write.
    @(negedge clk);
    MAB_in = 16'h0222; MDB_out = 16'hAAAA; MEM_WE = 1'b1; MEM_BW = 1'b0; MEM_REQ = 1'b1;
    @(posedge clk);
    #1 MEM_REQ = 1'b0;
    @(negedge clk);
    check("rstresp_wait_ack", MEM_ACK, 0);
    @(negedge clk);
    check("rstresp_resp_ack", MEM_ACK, 1);
    rst_n = 1'b0;
    @(negedge clk);
    check("rstresp_outs", {MEM_ACK, MEM_ERR, MDB_in}, 0);
    rst_n = 1'b1;
    run_vec("rstresp_read", 1'b0, 1'b0, 16'h0222, 16'h0000, 16'h0000, 1'b0);

    // Randomized traffic against the behavioural model, after filling the whole array.
    mdl_hold = 16'h0000;
    for (int i = 0; i < MDEP; i++)
      model_access(1'b1, 1'b0, 16'(MBASE + 2 * i), 16'($urandom));
    for (int i = 0; i < 300; i++) begin
      sel = int'($urandom_range(0, 9));
      if (sel < 8)       ra = 16'(MBASE + int'($urandom_range(0, 2 * MDEP - 1)));
      else if (sel == 8) ra = 16'(MBASE - 16 + int'($urandom_range(0, 31)));
      else               ra = 16'($urandom);
      model_access(1'($urandom), 1'($urandom), ra, 16'($urandom));
    end

    // Wait-state timing on the WS=0/3/7 instances.
    for (int k = 0; k < 3; k++) begin
      pat = 16'hC000 + 16'(k * 16'h0111);
      ws_access(k, 1'b1, 16'h0204, pat, lat, rd, er);
      check($sformatf("ws%0d_wr_lat", wsv[k]), lat, wsv[k] + 1);
      check($sformatf("ws%0d_wr_err", wsv[k]), er, 0);
      ws_access(k, 1'b0, 16'h0204, 16'h0000, lat, rd, er);
      check($sformatf("ws%0d_rd_lat", wsv[k]), lat, wsv[k] + 1);
      check($sformatf("ws%0d_rd_data", wsv[k]), rd, pat);
      ws_access(k, 1'b0, 16'h0700, 16'h0000, lat, rd, er);
      check($sformatf("ws%0d_oor_err", wsv[k]), {er, rd}, {1'b1, 16'h3FFF});
      ws_stream(k, wsv[k]);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_bus_responder.md
# mem_bus_responder

Memory-side responder for the MSP430 core's memory address bus (MAB) and memory data bus (MDB). It accepts one CPU-initiated access at a time from the MAB source-select path, supporting word or byte reads and writes. It decodes the address against a RAM window, inserts a programmable number of wait states, and returns read data on MDB with a one-cycle acknowledge. It is the target end of the bus whose address the CPU-side MAB mux drives.

## Interface
Parameters:
- `BASE_ADDR`, default 16'h0200: first byte address of the RAM window.
- `DEPTH_WORDS`, default 512: RAM size in 16-bit words; must be a power of two.
- `WAIT_STATES`, default 1: extra cycles between acceptance and acknowledge (0–7).

Ports:
- `clk`, input, 1: single system clock; all logic on the rising edge.
- `rst_n`, input, 1: reset, synchronous and active-low.
- `MAB_in`, input, 16: byte address from the CPU address mux.
- `MDB_out`, input, 16: write data from the CPU. For byte writes, data is in [7:0].
- `MEM_REQ`, input, 1: access request.
- `MEM_WE`, input, 1: 1 = write, 0 = read.
- `MEM_BW`, input, 1: 1 = byte access, 0 = word access.
- `MDB_in`, output, 16: read data returned to the CPU.
- `MEM_ACK`, output, 1: one-cycle completion pulse.
- `MEM_ERR`, output, 1: asserted with `MEM_ACK` when the address is outside the window.

## Operation
- The FSM has three states: IDLE, WAIT and RESP.
- **IDLE:**
  - When `MEM_REQ`=1, latch `MAB_in`, `MDB_out`, `MEM_WE` and `MEM_BW`, and decode the range.
  - If `WAIT_STATES`=0, go to RESP; otherwise load the wait counter with `WAIT_STATES` and go to WAIT.
- **WAIT:** decrement the counter each cycle; move to RESP when it reaches 1.
- **RESP:** assert `MEM_ACK` for exactly one cycle, then return to IDLE.
- Address decode:
  - In range when BASE_ADDR ≤ addr < BASE_ADDR + 2·DEPTH_WORDS, using a 17-bit compare so there is no wrap.
  - Word index is (addr − BASE_ADDR) >> 1.
  - Word accesses ignore addr[0] (forced even), matching MSP430 semantics; no alignment error.
- Read:
  - Word access: `MDB_in` = mem[idx].
  - Byte access: `MDB_in` = {8'h00, addr[0] ? mem[idx][15:8] : mem[idx][7:0]}.
  - Out-of-range read: `MDB_in` = 16'h3FFF (vacant-memory pattern) with `MEM_ERR`=1.
- Write:
  - The array is updated on the RESP cycle edge only.
  - Word access writes all 16 bits.
  - Byte access writes only lane addr[0] with `MDB_out`[7:0]; the other lane is preserved.
  - Out-of-range write: no array change; `MEM_ERR`=1. `MDB_in` is unchanged.
- `MDB_in` holds its value between accesses. It updates only on a read RESP.
- Requests are not accepted outside IDLE. `MEM_REQ` changes after acceptance are ignored; the latched access completes.

## Timing
- Reset values: state IDLE, `MEM_ACK`=0, `MEM_ERR`=0, `MDB_in`=16'h0000, counter 0. RAM contents are not reset.
- Latency: a request sampled at edge N gives `MEM_ACK` high during cycle N+1+WAIT_STATES.
- Back-to-back: a request is accepted earliest on the first IDLE edge after RESP, i.e. one dead cycle between accesses. The peak rate is one access per WAIT_STATES+2 cycles.
- `MDB_in` and `MEM_ERR` are valid in the same cycle as `MEM_ACK`. `MEM_ERR` is 0 whenever `MEM_ACK`=0.
- Reset mid-access (WAIT or RESP): the access is dropped, no write occurs, and the outputs take their reset values on the next edge.
- `MEM_REQ` held high continuously produces successive accesses using the bus values sampled on each IDLE edge.

## Structure
- Shared package `msp430_mem_pkg` holds:
  - the state enum (IDLE/WAIT/RESP);
  - the `VACANT_DATA` = 16'h3FFF constant;
  - the default RAM base and size constants, shared with the other memory-map decoders.
- One sub-module, `mem_ram_array`:
  - single-port, DEPTH_WORDS×16;
  - combinational read;
  - synchronous write with a 2-bit byte-lane enable.
- The FSM, decode and lane logic live in the top module.

## Test plan
1. **Word write/read:** write 16'hBEEF to 16'h0200, then read it back. Expect ACK at N+2 for WAIT_STATES=1, `MDB_in`=16'hBEEF, `MEM_ERR`=0.
2. **Byte lanes:** write word 16'h1234 to 16'h0210, then byte-write 8'hAB to 16'h0211. A word read returns 16'hAB34; a byte read of 16'h0210 returns 16'h0034.
3. **Odd word address:** word-read 16'h0201 after test 1. Expect 16'hBEEF, no error.
4. **Out of range:**
   - Read 16'h01FF: expect ACK with `MEM_ERR`=1 and `MDB_in`=16'h3FFF.
   - Write 16'h0600 (first address past the window for DEPTH_WORDS=512): expect `MEM_ERR`=1, and a subsequent read of 16'h05FE is unchanged.
5. **Wait states:** for WAIT_STATES of 0, 3 and 7, expect ACK exactly 1, 4 and 8 cycles after acceptance. With `MEM_REQ` held high, ACKs are spaced WAIT_STATES+2 cycles apart.
6. **Reset mid-access:** start a write of 16'h5555 to 16'h0220 (old value 16'h0000) and assert `rst_n`=0 during WAIT. Expect no ACK and all outputs 0; a read after reset returns 16'h0000.
